// File: rtl/vga_row_buffer.sv
// vga_row_buffer: ping-pong row buffer between vram_control and the VGA DAC.
// One bank fills from VRAM while the other plays out; banks swap on line_start.
module vga_row_buffer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [8:0]  disp_y,
  input  logic [9:0]  disp_x,
  input  logic        disp_active,
  input  logic [8:0]  y_tl,
  input  logic        VGA_we,
  input  logic [9:0]  VGA_x,
  input  logic [23:0] VGA_data,
  output logic        VGA_re,
  output logic [8:0]  VGA_y,
  output logic [23:0] pix_rgb,
  output logic        underrun
);
  typedef enum logic [1:0] {PRIME, FILL, READY} state_t;
  localparam logic [9:0] W = 10'(SCREEN_W);
  localparam logic [8:0] H = 9'(SCREEN_H);
  state_t      state_q;
  logic [9:0]  cnt_q, cnt_d;
  logic        rd_bank_q, blank_q, re_q, underrun_q;
  logic [8:0]  y_q, next_y;
  logic [23:0] pix_q;
  logic [23:0] mem [2][SCREEN_W];
  logic        wr_ok, ls_ok, filled;
  assign wr_ok  = VGA_we && state_q == FILL && VGA_x < W;
  assign cnt_d  = cnt_q + 10'(wr_ok);
  // A final write landing with line_start still counts, so the line swaps normally
  assign filled = state_q == READY || (state_q == FILL && cnt_d == W);
  assign ls_ok  = line_start && disp_y < H;
  assign next_y = ((disp_y == H - 9'd1) ? 9'd0 : disp_y + 9'd1) + y_tl;
  // While priming, the outgoing row is y_tl itself, so reset shows it without an async load
  assign VGA_y    = (state_q == PRIME) ? y_tl : y_q;
  assign VGA_re   = re_q;
  assign pix_rgb  = pix_q;
  assign underrun = underrun_q;
  always_ff @(posedge clk) begin
    if (wr_ok) mem[~rd_bank_q][VGA_x] <= VGA_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRIME;
      cnt_q      <= '0;
      rd_bank_q  <= 1'b0;
      blank_q    <= 1'b1;
      re_q       <= 1'b0;
      underrun_q <= 1'b0;
      y_q        <= '0;
      pix_q      <= '0;
    end else begin
      re_q  <= 1'b0;
      pix_q <= (disp_active && disp_x < W && !blank_q) ? mem[rd_bank_q][disp_x] : '0;
      if (ls_ok || state_q == PRIME) begin
        re_q    <= 1'b1;
        cnt_q   <= '0;
        state_q <= FILL;
        y_q     <= ls_ok ? next_y : y_tl;
        if (ls_ok && filled) begin
          rd_bank_q <= ~rd_bank_q;
          blank_q   <= 1'b0;
        end else if (ls_ok) begin
          underrun_q <= 1'b1;
          blank_q    <= 1'b1;
        end
      end else if (state_q == FILL) begin
        cnt_q <= cnt_d;
        if (cnt_d == W) state_q <= READY;
      end
    end
  end
endmodule

// File: doc/vga_row_buffer.md
Name: vga_row_buffer

Overview:
- Ping-pong row buffer that sits directly downstream of vram_control, on the display side.
- Requests one VRAM row per display line via VGA_re/VGA_y, captures the pixels vram_control streams out (VGA_we/VGA_x/VGA_data) into the fill bank, and plays the other bank out to the VGA DAC.
- Decouples SRAM row fetch from pixel timing, so the GPU owns SRAM for most of each line.

Parameters:
- SCREEN_W, 640, pixels per row; bank depth; matches the screen width vram_control uses.
- SCREEN_H, 480, active display lines.

Ports:
- clk  in  1  system clock, all logic posedge.
- rst_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse from timing generator at start of each display line.
- disp_y  in  9  display line number, valid with line_start.
- disp_x  in  10  current display pixel column.
- disp_active  in  1  high in visible region.
- y_tl  in  9  display-area top line in VRAM.
- VGA_we  in  1  pixel-write strobe from vram_control.
- VGA_x  in  10  pixel column for VGA_we.
- VGA_data  in  24  RGB888 pixel for VGA_we.
- VGA_re  out  1  one-cycle row-fetch request to vram_control.
- VGA_y  out  9  VRAM row to fetch; held stable for the whole fill.
- pix_rgb  out  24  registered pixel to DAC.
- underrun  out  1  sticky: a line started before its fill completed.

Behaviour:
- Reset (async, rst_n low): VGA_re=0, VGA_y=y_tl, pix_rgb=0, underrun=0, rd_bank=0, FSM=PRIME. Bank RAM contents are not cleared.
- FSM states:
  - PRIME: one cycle after reset release; pulse VGA_re with VGA_y=y_tl (line 0) into bank 1; go to FILL.
  - FILL: capture writes; on count==SCREEN_W go to READY.
  - READY: wait for line_start; then swap banks and issue the next request (go to FILL).
  - FILL with line_start: underrun case (see below).
- Request rule: on an accepted line_start with disp_y<SCREEN_H, next=(disp_y==SCREEN_H-1)?0:disp_y+1.
  - VGA_y <= (next+y_tl) mod 512; VGA_re=1 for exactly one cycle, the cycle after line_start.
  - Never asserted again before the current fill completes.
- line_start with disp_y>=SCREEN_H: ignored (no swap, no request).
- Write capture:
  - When VGA_we && FSM==FILL && VGA_x<SCREEN_W: write VGA_data to fill bank[VGA_x] and increment the 10-bit write count.
  - VGA_we outside FILL, or with VGA_x>=SCREEN_W: dropped, not counted.
- Fill complete: count reaches SCREEN_W; count resets to 0 at each request.
- Swap: on line_start in READY, rd_bank <= fill bank; fill bank becomes the old read bank.
- Underrun: line_start in FILL or PRIME.
  - Set underrun; do not swap.
  - Blank the line (pix_rgb=0 for the whole line).
  - Abandon the partial fill; reissue the request for the new next line; count<=0.
  - An in-flight vram_control service still completes; its later writes land in the fill bank and are counted toward the new request.
- Simultaneous line_start and final VGA_we: the write completes first, so the line counts as READY and a normal swap occurs.
- Read: pix_rgb <= (disp_active && disp_x<SCREEN_W && !blank) ? bank[rd_bank][disp_x] : 0.
  - Latency: exactly 1 clk from disp_x to pix_rgb.
  - Writes and reads target different banks, so there is no read-write collision.
- underrun clears only on reset.

Test Plan:
- Reset release, y_tl=0 -> VGA_re high exactly one cycle, 1 clk after release, VGA_y=0; stream 640 writes VGA_x 0..639 with data={x,x,x}; FSM reaches READY.
- After fill, line_start with disp_y=0 -> swap; sweep disp_x 0..639 with disp_active=1 -> pix_rgb equals written data 1 clk later; VGA_re pulses with VGA_y=1.
- disp_y=479, y_tl=40 -> request VGA_y=40 (line 0 of next frame); disp_y=100, y_tl=500 -> VGA_y=(101+500) mod 512=89.
- line_start after only 300 writes -> underrun=1, pix_rgb=0 for the whole line, new VGA_re issued, no swap.
- Final write (VGA_x=639) in the same cycle as line_start -> normal swap, underrun stays 0.
- Stray VGA_we in READY, VGA_we with VGA_x=640, rst_n dropped mid-fill at count=200 -> writes dropped; after reset all outputs are 0 and the PRIME request is reissued.
